spi_cmd_decoder: RTL and testbench

SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

---
 rtl/spi_cmd_decoder.sv | 159 +++++++++++++++
 tb/tb_spi_cmd_decoder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : spi_cmd_decoder
//  Description : Decodes byte frames delivered by an SPI slave into register
//                reads and writes. The register map has a fixed ID, six
//                read/write configuration registers and a saturating error
//                counter. Transactions abandoned by the master are aborted
//                after TIMEOUT_CYCLES idle cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_cmd_decoder #(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic [7:0]  rxd_data,
    input  logic        rxd_flag,
    output logic [7:0]  txd_data,
    output logic [47:0] cfg_regs,
    output logic        wr_pulse,
    output logic [2:0]  wr_addr,
    output logic        busy
);

    // Transaction states
    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_WR_DATA  = 2'd1;
    localparam logic [1:0] c_RD_DUMMY = 2'd2;

    // Fixed register contents and response bytes
    localparam logic [7:0] c_ID_VALUE = 8'h5A;
    localparam logic [7:0] c_ERR_RESP = 8'hEE;
    localparam logic [7:0] c_ERR_MAX  = 8'hFF;

    logic [1:0]  r_state;
    logic [2:0]  r_addr;
    logic [7:0]  r_txd;
    logic [47:0] r_cfg;
    logic        r_wr_pulse;
    logic [2:0]  r_wr_addr;
    logic [7:0]  r_err_cnt;
    logic [19:0] r_tmo_cnt;

    logic        w_busy;
    logic        w_cmd_legal;
    logic        w_timeout;
    logic        w_wr_fire;
    logic        w_addr_rw;
    logic        w_err_inc;
    logic [7:0]  w_rd_val;

    assign w_busy      = (r_state != c_IDLE);
    assign w_cmd_legal = (rxd_data[6:3] == 4'd0);
    // Abort fires on the idle cycle that would bring the count up to the limit;
    // a frame arriving in that same cycle takes priority.
    assign w_timeout   = w_busy && !rxd_flag &&
                         (({1'b0, r_tmo_cnt} + 21'd1) >= {1'b0, TIMEOUT_CYCLES});
    assign w_wr_fire   = (r_state == c_WR_DATA) && rxd_flag;
    assign w_addr_rw   = (r_addr != 3'd0) && (r_addr != 3'd7);
    assign w_err_inc   = ((r_state == c_IDLE) && rxd_flag && !w_cmd_legal) || w_timeout;

    // Read mux keyed by the address field of the incoming command byte
    always_comb begin
        w_rd_val = 8'h00;
        case (rxd_data[2:0])
            3'd0:    w_rd_val = c_ID_VALUE;
            3'd1:    w_rd_val = r_cfg[7:0];
            3'd2:    w_rd_val = r_cfg[15:8];
            3'd3:    w_rd_val = r_cfg[23:16];
            3'd4:    w_rd_val = r_cfg[31:24];
            3'd5:    w_rd_val = r_cfg[39:32];
            3'd6:    w_rd_val = r_cfg[47:40];
            default: w_rd_val = r_err_cnt;
        endcase
    end

    // Transaction FSM, captured address and response byte
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_addr  <= 3'd0;
            r_txd   <= 8'h00;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (rxd_flag) begin
                        if (!w_cmd_legal) begin
                            r_txd <= c_ERR_RESP;
                        end else if (rxd_data[7]) begin
                            r_addr  <= rxd_data[2:0];
                            r_state <= c_WR_DATA;
                        end else begin
                            r_txd   <= w_rd_val;
                            r_state <= c_RD_DUMMY;
                        end
                    end
                end
                c_WR_DATA, c_RD_DUMMY: begin
                    if (rxd_flag || w_timeout) begin
                        r_state <= c_IDLE;
                        r_txd   <= 8'h00;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Inter-frame idle counter, only running inside a transaction
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= 20'd0;
        end else if (!w_busy || rxd_flag || w_timeout) begin
            r_tmo_cnt <= 20'd0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 20'd1;
        end
    end

    // Configuration register file and write strobe
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg      <= 48'h0;
            r_wr_pulse <= 1'b0;
            r_wr_addr  <= 3'd0;
        end else begin
            r_wr_pulse <= 1'b0;
            if (w_wr_fire && w_addr_rw) begin
                r_wr_pulse <= 1'b1;
                r_wr_addr  <= r_addr;
                for (int n = 1; n <= 6; n++) begin
                    if (r_addr == 3'(n)) begin
                        r_cfg[8*n-8 +: 8] <= rxd_data;
                    end
                end
            end
        end
    end

    // Saturating error counter, cleared by any write to its address
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= 8'h00;
        end else if (w_wr_fire && (r_addr == 3'd7)) begin
            r_err_cnt <= 8'h00;
        end else if (w_err_inc && (r_err_cnt != c_ERR_MAX)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign txd_data = r_txd;
    assign cfg_regs = r_cfg;
    assign wr_pulse = r_wr_pulse;
    assign wr_addr  = r_wr_addr;
    assign busy     = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_spi_cmd_decoder
//  Description : Scoreboard bench for spi_cmd_decoder. A frame-level model
//                predicts the outputs after each frame or abort; a monitor
//                compares them on the cycle they are due.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_cmd_decoder;

    localparam int c_TMO = 16;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic [7:0]  rxd_data = 8'h00;
    logic        rxd_flag = 1'b0;
    logic [7:0]  txd_data;
    logic [47:0] cfg_regs;
    logic        wr_pulse;
    logic [2:0]  wr_addr;
    logic        busy;

    spi_cmd_decoder #(.TIMEOUT_CYCLES(20'd16)) dut (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .rxd_data (rxd_data),
        .rxd_flag (rxd_flag),
        .txd_data (txd_data),
        .cfg_regs (cfg_regs),
        .wr_pulse (wr_pulse),
        .wr_addr  (wr_addr),
        .busy     (busy)
    );

    always #5 sys_clk = ~sys_clk;

    // Rising-edge count; stable when sampled on the falling edge
    int unsigned cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  txd;
        logic        busy;
        logic        wp;
        logic [2:0]  wa;
        logic [47:0] cfg;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", nm, cyc, act, req);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    logic [7:0] m_reg [1:6];
    logic [7:0] m_err;
    logic [7:0] m_txd;
    int         m_pend;      // 0 none, 1 awaiting write data, 2 awaiting dummy
    logic [2:0] m_paddr;

    task automatic model_reset();
        for (int n = 1; n <= 6; n++) m_reg[n] = 8'h00;
        m_err   = 8'h00;
        m_txd   = 8'h00;
        m_pend  = 0;
        m_paddr = 3'd0;
    endtask

    function automatic logic [47:0] model_cfg();
        logic [47:0] r;
        r = 48'h0;
        for (int n = 1; n <= 6; n++) r[8*n-8 +: 8] = m_reg[n];
        return r;
    endfunction

    task automatic bump_err();
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
    endtask

    // Predict the effect of one frame driven at rising-edge count c, followed
    // by gap idle cycles, and queue the expected outputs.
    task automatic model_frame(input logic [7:0] b, input int gap, input int unsigned c);
        exp_t e;
        e.wp = 1'b0;
        e.wa = 3'd0;
        if (m_pend == 0) begin
            if (b[6:3] != 4'd0) begin
                m_txd = 8'hEE;
                bump_err();
            end else if (b[7]) begin
                m_pend  = 1;
                m_paddr = b[2:0];
            end else begin
                if (b[2:0] == 3'd0)      m_txd = 8'h5A;
                else if (b[2:0] == 3'd7) m_txd = m_err;
                else                     m_txd = m_reg[int'(b[2:0])];
                m_pend = 2;
            end
        end else if (m_pend == 1) begin
            m_txd = 8'h00;
            if (m_paddr == 3'd7) begin
                m_err = 8'h00;
            end else if (m_paddr != 3'd0) begin
                m_reg[int'(m_paddr)] = b;
                e.wp = 1'b1;
                e.wa = m_paddr;
            end
            m_pend = 0;
        end else begin
            m_txd  = 8'h00;
            m_pend = 0;
        end
        e.cyc  = c + 1;
        e.txd  = m_txd;
        e.busy = (m_pend != 0);
        e.cfg  = model_cfg();
        exp_q.push_back(e);
        if (m_pend != 0 && gap >= c_TMO) begin
            m_pend = 0;
            m_txd  = 8'h00;
            bump_err();
            e.cyc  = c + 1 + c_TMO;
            e.txd  = m_txd;
            e.busy = 1'b0;
            e.wp   = 1'b0;
            e.cfg  = model_cfg();
            exp_q.push_back(e);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge sys_clk) begin : mon
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            chk("txd_data", 64'(txd_data), 64'(e.txd));
            chk("busy",     64'(busy),     64'(e.busy));
            chk("cfg_regs", 64'(cfg_regs), 64'(e.cfg));
            chk("wr_pulse", 64'(wr_pulse), 64'(e.wp));
            if (e.wp) chk("wr_addr", 64'(wr_addr), 64'(e.wa));
        end else begin
            chk("wr_pulse_idle", 64'(wr_pulse), 64'd0);
        end
    end

    // ---------------- driver ----------------
    // Called on a falling edge; returns on the falling edge where the next
    // frame may be driven.
    task automatic send(input logic [7:0] b, input int gap);
        rxd_data = b;
        rxd_flag = 1'b1;
        model_frame(b, gap, cyc);
        @(negedge sys_clk);
        rxd_flag = 1'b0;
        rxd_data = 8'($urandom);
        repeat (gap) @(negedge sys_clk);
    endtask

    task automatic chk_reset_values();
        chk("rst_txd",   64'(txd_data), 64'd0);
        chk("rst_cfg",   64'(cfg_regs), 64'd0);
        chk("rst_busy",  64'(busy),     64'd0);
        chk("rst_wrp",   64'(wr_pulse), 64'd0);
        chk("rst_wradr", 64'(wr_addr),  64'd0);
    endtask

    function automatic int rand_gap();
        int k;
        k = int'($urandom_range(0, 9));
        if (k <= 5) return int'($urandom_range(0, 3));
        if (k == 6) return 15;
        if (k == 7) return 16;
        if (k == 8) return int'($urandom_range(17, 20));
        return 0;
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        logic [7:0] b;
        model_reset();
        repeat (3) @(negedge sys_clk);
        chk_reset_values();
        rst_n = 1'b1;

        // Write then read back
        send(8'h83, 2);
        send(8'h3C, 2);
        send(8'h03, 1);
        send(8'h77, 2);
        // ID read, then attempted ID write
        send(8'h00, 1);
        send(8'h12, 1);
        send(8'h80, 1);
        send(8'hFF, 1);
        send(8'h00, 0);
        send(8'h00, 2);
        // Illegal command, error count read, clear
        send(8'h48, 1);
        send(8'h07, 1);
        send(8'h00, 1);
        send(8'h87, 1);
        send(8'h00, 1);
        send(8'h07, 1);
        send(8'h00, 1);
        // Timeout abort, then frame landing on the expiry cycle
        send(8'h81, 16);
        send(8'h07, 1);
        send(8'h00, 1);
        send(8'h81, 15);
        send(8'hA5, 2);
        send(8'h07, 1);
        send(8'h00, 1);
        send(8'h02, 20);
        // Saturation
        for (int i = 0; i < 300; i++) begin
            b = 8'($urandom);
            b[6:3] = 4'(($urandom_range(1, 15)));
            send(b, 0);
        end
        send(8'h07, 1);
        send(8'h00, 1);
        send(8'h87, 1);
        send(8'h00, 1);
        // Reset in the middle of a write
        send(8'h85, 2);
        #2 rst_n = 1'b0;
        #1 chk_reset_values();
        @(negedge sys_clk);
        rst_n = 1'b1;
        model_reset();
        send(8'h11, 3);
        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 3) != 0) b[6:3] = 4'd0;
            send(b, rand_gap());
        end
        repeat (25) @(negedge sys_clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
